// File: rtl/store_pkg.sv
// Shared encodings for the store lane unit: request sizes, FSM states and
// the alignment rule used to reject a store before it touches memory.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // True when the request cannot be performed: illegal size or an address
  // that is not naturally aligned for the access width.
  function automatic logic store_faults(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: store_faults = 1'b0;
      SZ_HALF: store_faults = lo[0];
      SZ_WORD: store_faults = (lo != 2'b00);
      default: store_faults = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Little-endian lane merge: overlays the narrowed store data onto the word
// read from memory, leaving unwritten lanes untouched.
module lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  // Select which lanes of the old word are replaced by store data.
  always_comb begin
    merged = old_word;
    case (size_e'(size))
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = store_data[7:0];
          2'd1:    merged[15:8]  = store_data[7:0];
          2'd2:    merged[23:16] = store_data[7:0];
          default: merged[31:24] = store_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) merged[31:16] = store_data[15:0];
        else            merged[15:0]  = store_data[15:0];
      end
      default: merged = store_data;
    endcase
  end

endmodule

// File: rtl/store_lane_unit.sv
// Store path to word-wide data memory without byte enables: narrows sb/sh/sw
// data and performs read-modify-write under valid/ready and memory handshakes.
module store_lane_unit
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              done,
  output logic              fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wack
);

  state_e            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic              req_fault;

  assign req_fault = store_faults(size_e'(req_size), req_addr[1:0]);

  // Next-state and request/read-data capture; stray handshakes fall through
  // because each is only examined in the state that expects it.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          fault_d = req_fault;
          if (req_fault)                         state_d = ST_DONE;
          else if (size_e'(req_size) == SZ_WORD) state_d = ST_WRITE;
          else                                   state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_wack) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-request registers; reset discards any request in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // The merged word depends only on registered values, so mem_wdata is
  // stable through WRITE and has no path from mem_rdata.
  lane_merge u_lane_merge (
    .old_word   (rdata_q),
    .store_data (wdata_q),
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .merged     (mem_wdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign mem_rd    = (state_q == ST_READ);
  assign mem_wr    = (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign fault     = (state_q == ST_DONE) && fault_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_store_lane_unit.sv
// Self-checking bench for store_lane_unit: directed vector table, a
// hand-written reset-mid-write sequence and randomized stores against a model.
module tb_store_lane_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic        fault;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_wack;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  store_lane_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .done       (done),
    .fault      (fault),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_wack   (mem_wack)
  );

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] memw;
    int          rdw;
    int          wrw;
    bit          stray;
    logic [31:0] exp_wd;
    bit          exp_f;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: behaviour written from the store rules, not the RTL.
  function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] model_merge(input logic [1:0] sz, input logic [31:0] a,
                                              input logic [31:0] wd, input logic [31:0] mw);
    int unsigned sh;
    if (sz == 2'd0) begin
      sh = 8 * a[1:0];
      return (mw & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end else if (sz == 2'd1) begin
      sh = 16 * a[1];
      return (mw & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  function automatic int model_lat(input logic [1:0] sz, input logic [31:0] a,
                                   input int rdw, input int wrw);
    if (model_fault(sz, a)) return 1;
    if (sz == 2'd2) return wrw + 2;
    return rdw + wrw + 3;
  endfunction

  // Issue one store at the current cycle, act as memory, and check the outcome.
  task automatic run_op(input vec_t v, input string tag);
    int   c, rdc, wrc, done_c;
    bit   saw_rd, saw_wr, addr_ok, wd_stable, f_seen, have_wd;
    logic [31:0] wd_seen, exp_addr;
    exp_addr = {v.addr[31:2], 2'b00};
    req_valid = 1'b1;
    req_size  = v.sz;
    req_addr  = v.addr;
    req_wdata = v.wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_size  = 2'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    chk({tag, " ready_low"}, {31'd0, req_ready}, 32'd0);
    c = 1; rdc = 0; wrc = 0; done_c = -1;
    saw_rd = 0; saw_wr = 0; addr_ok = 1; wd_stable = 1; f_seen = 0; have_wd = 0;
    wd_seen = '0;
    while (done_c < 0 && c < 60) begin
      mem_rvalid = 1'b0;
      mem_wack   = 1'b0;
      mem_rdata  = $urandom;
      if (mem_rd) begin
        saw_rd = 1;
        if (mem_addr !== exp_addr) addr_ok = 0;
        if (rdc == v.rdw) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.memw;
        end
        rdc++;
        mem_wack = v.stray && (rdc % 2 == 1);
      end else if (mem_wr) begin
        saw_wr = 1;
        if (mem_addr !== exp_addr) addr_ok = 0;
        if (!have_wd) begin
          wd_seen = mem_wdata;
          have_wd = 1;
        end else if (mem_wdata !== wd_seen) begin
          wd_stable = 0;
        end
        mem_wack   = (wrc == v.wrw);
        mem_rvalid = v.stray;
        wrc++;
      end
      if (done) begin
        done_c = c;
        f_seen = fault;
      end
      @(posedge clk); #1;
      c++;
    end
    mem_rvalid = 1'b0;
    mem_wack   = 1'b0;
    chk({tag, " latency"}, done_c, v.exp_lat);
    chk({tag, " fault"}, {31'd0, f_seen}, {31'd0, v.exp_f});
    chk({tag, " rd_used"}, {31'd0, saw_rd}, {31'd0, !v.exp_f && v.sz != 2'd2});
    chk({tag, " wr_used"}, {31'd0, saw_wr}, {31'd0, !v.exp_f});
    if (!v.exp_f) begin
      chk({tag, " wdata"}, wd_seen, v.exp_wd);
      chk({tag, " addr_stable"}, {31'd0, addr_ok}, 32'd1);
      chk({tag, " wdata_stable"}, {31'd0, wd_stable}, 32'd1);
    end
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    rst_n = 1'b0; req_valid = 1'b0; req_size = '0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;

    tbl[0] = '{2'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'hDEADBEEF, 0, 2};
    tbl[1] = '{2'd0, 32'h13, 32'h123456AB, 32'h11223344, 0, 0, 0, 32'hAB223344, 0, 3};
    tbl[2] = '{2'd1, 32'h06, 32'h0000CAFE, 32'hFFFFFFFF, 0, 0, 0, 32'hCAFEFFFF, 0, 3};
    tbl[3] = '{2'd1, 32'h05, 32'h11111111, 32'h0,        0, 0, 0, 32'h0,        1, 1};
    tbl[4] = '{2'd2, 32'h02, 32'h22222222, 32'h0,        0, 0, 0, 32'h0,        1, 1};
    tbl[5] = '{2'd3, 32'h00, 32'h33333333, 32'h0,        0, 0, 0, 32'h0,        1, 1};
    tbl[6] = '{2'd1, 32'h04, 32'h1234BEEF, 32'hAABBCCDD, 3, 2, 1, 32'hAABBBEEF, 0, 8};
    tbl[7] = '{2'd0, 32'h01, 32'h0000005A, 32'h00000000, 0, 0, 0, 32'h00005A00, 0, 3};

    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst fault", {31'd0, fault}, 32'd0);
    chk("rst mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset asserted while a word store waits for its write acknowledge.
    req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'h01020304;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstw in_write", {31'd0, mem_wr}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstw mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rstw ready", {31'd0, req_ready}, 32'd1);
    chk("rstw done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstw no_done", {31'd0, done}, 32'd0);
    v = '{2'd2, 32'h44, 32'hCAFEF00D, 32'h0, 0, 0, 0, 32'hCAFEF00D, 0, 2};
    run_op(v, "post_rst");

    for (int i = 0; i < 40; i++) begin
      v.sz    = 2'($urandom_range(0, 3));
      v.addr  = {$urandom_range(0, 255), 2'($urandom)};
      v.wd    = $urandom;
      v.memw  = $urandom;
      v.rdw   = $urandom_range(0, 3);
      v.wrw   = $urandom_range(0, 3);
      v.stray = 1'($urandom);
      v.exp_f   = model_fault(v.sz, v.addr);
      v.exp_wd  = model_merge(v.sz, v.addr, v.wd, v.memw);
      v.exp_lat = model_lat(v.sz, v.addr, v.rdw, v.wrw);
      run_op(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
